// File: rtl/datapath_src_mux51_sched.sv
// -----------------------------------------------------------------------------
// datapath_src_mux51_sched
// Burst-locking scheduler for a 5:1 handshake source mux (sources A..E).
// Picks a winner among the source valids (round-robin or fixed priority) and
// holds the mux select for a programmable burst of beats. While no grant is
// held, the downstream handshake is gated off.
//
// Optional feature macro: DATAPATH_SRC_MUX51_SCHED_LAST_EN
//   When defined, adds src_last[4:0]. A beat carrying the granted source's
//   last flag ends the burst early, exactly like the final counted beat.
//   When undefined, a burst ends purely on the beat count.
// -----------------------------------------------------------------------------
module datapath_src_mux51_sched #(
    parameter int unsigned BL_W  = 4,
    parameter int unsigned SRC_N = 5    // fixed at 5: the select encoding assumes it
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SRC_N-1:0]  src_valid,
`ifdef DATAPATH_SRC_MUX51_SCHED_LAST_EN
    input  logic [SRC_N-1:0]  src_last,
`endif
    input  logic [BL_W-1:0]   cfg_burst_len,
    input  logic              cfg_fix_prio,
    output logic [2:0]        mux_sel,
    input  logic              mux_z_valid,
    output logic              mux_z_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SRC_N-1:0]  gnt_onehot,
    output logic              busy
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Beat counter is one bit wider so a zero config can load 2**BL_W.
    localparam logic [BL_W:0] CNT_ONE  = {{BL_W{1'b0}}, 1'b1};
    localparam logic [BL_W:0] CNT_FULL = {1'b1, {BL_W{1'b0}}};

    // -------------------------------------------------------------------------
    // Arbitration helpers
    // -------------------------------------------------------------------------

    // Fixed priority: the lowest-index requester wins (A > B > C > D > E).
    function automatic logic [2:0] fix_pick(input logic [4:0] req);
        logic [2:0] win;
        casez (req)
            5'b????1: win = 3'd0;
            5'b???10: win = 3'd1;
            5'b??100: win = 3'd2;
            5'b?1000: win = 3'd3;
            5'b10000: win = 3'd4;
            default:  win = 3'd0;
        endcase
        return win;
    endfunction

    // Round-robin: search starts one past the last winner, wrapping E -> A.
    function automatic logic [2:0] rr_pick(input logic [4:0] req,
                                           input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        idx   = ptr;
        win   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (idx >= 3'd4) begin
                idx = 3'd0;
            end else begin
                idx = idx + 3'd1;
            end
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // Binary select to one-hot grant.
    function automatic logic [4:0] sel_to_onehot(input logic [2:0] sel);
        logic [4:0] oh;
        case (sel)
            3'd0:    oh = 5'b00001;
            3'd1:    oh = 5'b00010;
            3'd2:    oh = 5'b00100;
            3'd3:    oh = 5'b01000;
            3'd4:    oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    // -------------------------------------------------------------------------
    // Registers and next-state signals
    // -------------------------------------------------------------------------
    logic [0:0]       state_q,  state_d;
    logic [2:0]       sel_q,    sel_d;
    logic [4:0]       gnt_q,    gnt_d;
    logic [BL_W:0]    cnt_q,    cnt_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;

    logic             busy_s;
    logic             beat_s;
    logic             cnt_last_s;
    logic             last_flag_s;
    logic             final_s;
    logic             any_req_s;
    logic [2:0]       winner_s;
    logic [BL_W:0]    load_cnt_s;

    assign busy_s    = (state_q == ST_BUSY);
    assign any_req_s = |src_valid;

    // Handshake gating and beat detection.
    always_comb begin
        out_valid   = busy_s & mux_z_valid;
        mux_z_ready = busy_s & out_ready;
        beat_s      = busy_s & mux_z_valid & out_ready;
    end

    // End-of-burst detection: final counted beat, or an early last flag.
    always_comb begin
        cnt_last_s = (cnt_q == CNT_ONE);
`ifdef DATAPATH_SRC_MUX51_SCHED_LAST_EN
        last_flag_s = src_last[sel_q];
`else
        last_flag_s = 1'b0;
`endif
        // Both conditions together still produce a single release.
        final_s = beat_s & (cnt_last_s | last_flag_s);
    end

    // Winner selection and burst length for the next grant load.
    always_comb begin
        if (cfg_fix_prio) begin
            winner_s = fix_pick(src_valid);
        end else begin
            winner_s = rr_pick(src_valid, rr_ptr_q);
        end
        if (cfg_burst_len == {BL_W{1'b0}}) begin
            load_cnt_s = CNT_FULL;
        end else begin
            load_cnt_s = {1'b0, cfg_burst_len};
        end
    end

    // Scheduler next-state: grant load, beat countdown, release.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d  = ST_BUSY;
                    sel_d    = winner_s;
                    gnt_d    = sel_to_onehot(winner_s);
                    cnt_d    = load_cnt_s;
                    rr_ptr_d = winner_s;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (final_s) begin
                    if (any_req_s) begin
                        // Zero-bubble hand-over; the same source may win again.
                        state_d  = ST_BUSY;
                        sel_d    = winner_s;
                        gnt_d    = sel_to_onehot(winner_s);
                        cnt_d    = load_cnt_s;
                        rr_ptr_d = winner_s;
                    end else begin
                        state_d  = ST_IDLE;
                        gnt_d    = 5'b00000;
                        cnt_d    = {(BL_W+1){1'b0}};
                    end
                end else if (beat_s) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    // Stall: select, grant and count all hold.
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                sel_d    = 3'd0;
                gnt_d    = 5'b00000;
                cnt_d    = {(BL_W+1){1'b0}};
                rr_ptr_d = 3'd4;
            end
        endcase
    end

    // Scheduler state registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= 3'd0;
            gnt_q    <= 5'b00000;
            cnt_q    <= {(BL_W+1){1'b0}};
            rr_ptr_q <= 3'd4;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign mux_sel    = sel_q;
    assign gnt_onehot = gnt_q;
    assign busy       = busy_s;

endmodule

// File: tb/tb_datapath_src_mux51_sched.sv
// -----------------------------------------------------------------------------
// Self-checking bench for datapath_src_mux51_sched.
// Directed scenarios plus randomized traffic, all checked against a
// transaction-level model (granted source, beats left, last winner).
// -----------------------------------------------------------------------------
module tb_datapath_src_mux51_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] src_valid;
    logic [4:0] src_last;
    logic [3:0] cfg_burst_len;
    logic       cfg_fix_prio;
    logic [2:0] mux_sel;
    logic       mux_z_valid;
    logic       mux_z_ready;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] gnt_onehot;
    logic       busy;

    always #5 clk = ~clk;

    datapath_src_mux51_sched #(.BL_W(4), .SRC_N(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_valid     (src_valid),
`ifdef DATAPATH_SRC_MUX51_SCHED_LAST_EN
        .src_last      (src_last),
`endif
        .cfg_burst_len (cfg_burst_len),
        .cfg_fix_prio  (cfg_fix_prio),
        .mux_sel       (mux_sel),
        .mux_z_valid   (mux_z_valid),
        .mux_z_ready   (mux_z_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .gnt_onehot    (gnt_onehot),
        .busy          (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transaction-level view of the scheduler.
    int m_busy;   // a grant is held
    int m_src;    // granted source index
    int m_left;   // beats remaining in the burst
    int m_ptr;    // last winner (round-robin origin)
    int m_sel;    // select value presented to the mux

    // Observations from the most recent cycle.
    int obs_sel;
    int obs_busy;
    int beats;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int req, input int ptr, input int fp);
        if (fp != 0) begin
            for (int i = 0; i < 5; i++) if (((req >> i) & 1) != 0) return i;
        end else begin
            for (int k = 1; k <= 5; k++) begin
                int idx;
                idx = (ptr + k) % 5;
                if (((req >> idx) & 1) != 0) return idx;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_src = 0; m_left = 0; m_ptr = 4; m_sel = 0;
    endtask

    // One clock: drive inputs, check against model, advance model and DUT.
    task automatic cycle(input logic [4:0] sv, input logic [3:0] bl, input logic fp,
                         input logic zv, input logic ordy, input logic [4:0] lst);
        int  w;
        int  done;
        int  beat;
        src_valid = sv; cfg_burst_len = bl; cfg_fix_prio = fp;
        mux_z_valid = zv; out_ready = ordy; src_last = lst;
        #1;
        chk("busy",      32'(busy),        32'(m_busy));
        chk("mux_sel",   32'(mux_sel),     32'(m_sel));
        chk("gnt",       32'(gnt_onehot),  (m_busy != 0) ? (32'd1 << m_src) : 32'd0);
        chk("out_valid", 32'(out_valid),   32'((m_busy != 0) && zv));
        chk("z_ready",   32'(mux_z_ready), 32'((m_busy != 0) && ordy));
        obs_sel  = int'(mux_sel);
        obs_busy = int'(busy);
        if (out_valid && out_ready) beats++;
        beat = ((m_busy != 0) && zv && ordy) ? 1 : 0;
        done = 0;
        if (beat != 0) begin
            m_left--;
            if (m_left == 0) done = 1;
`ifdef DATAPATH_SRC_MUX51_SCHED_LAST_EN
            if (lst[m_src]) done = 1;
`endif
        end
        if (m_busy == 0 || done != 0) begin
            if (sv != 5'd0) begin
                w = pick(int'(sv), m_ptr, int'(fp));
                m_busy = 1; m_src = w; m_sel = w; m_ptr = w;
                m_left = (bl == 4'd0) ? 16 : int'(bl);
            end else begin
                m_busy = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset mid-cycle; outputs must drop before any clock edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_z_ready",   32'(mux_z_ready), 32'd0);
        chk("rst_gnt",       32'(gnt_onehot),  32'd0);
        chk("rst_sel",       32'(mux_sel),     32'd0);
        src_valid = 5'd0; mux_z_valid = 1'b0; out_ready = 1'b0; src_last = 5'd0;
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int cnt_c;
    int cnt_b;
    int exp_seq [6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        rst_n = 1'b0; src_valid = 5'd0; src_last = 5'd0; cfg_burst_len = 4'd0;
        cfg_fix_prio = 1'b0; mux_z_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        #22;
        chk("init_busy", 32'(busy),       32'd0);
        chk("init_gnt",  32'(gnt_onehot), 32'd0);
        chk("init_sel",  32'(mux_sel),    32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request on A, burst of 3.
        beats = 0;
        cycle(5'b00001, 4'd3, 1'b0, 1'b1, 1'b1, 5'd0);
        cycle(5'b00000, 4'd3, 1'b0, 1'b1, 1'b1, 5'd0);
        chk("s1_sel_A", 32'(obs_sel), 32'd0);
        for (int i = 0; i < 4; i++) cycle(5'b00000, 4'd3, 1'b0, 1'b1, 1'b1, 5'd0);
        chk("s1_beats", 32'(beats), 32'd3);
        chk("s1_idle",  32'(obs_busy), 32'd0);

        // Round-robin, all requesting, burst of 1: A,B,C,D,E,A back to back.
        do_reset();
        cycle(5'b11111, 4'd1, 1'b0, 1'b1, 1'b1, 5'd0);
        for (int i = 0; i < 6; i++) begin
            cycle(5'b11111, 4'd1, 1'b0, 1'b1, 1'b1, 5'd0);
            chk("s2_rr_sel",  32'(obs_sel),  32'(exp_seq[i]));
            chk("s2_rr_busy", 32'(obs_busy), 32'd1);
        end

        // Fixed priority with B and C requesting: B always wins.
        do_reset();
        cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(5'b00110, 4'd2, 1'b1, 1'b1, 1'b1, 5'd0);
            if (obs_busy != 0 && obs_sel == 1) cnt_b++;
            if (obs_busy != 0 && obs_sel == 2) cnt_c++;
        end
        chk("s3_b_grants", 32'(cnt_b), 32'd11);
        chk("s3_c_grants", 32'(cnt_c), 32'd0);

        // Burst of 2 on C with a 4-cycle downstream stall between beats.
        do_reset();
        beats = 0;
        cycle(5'b00100, 4'd2, 1'b0, 1'b1, 1'b1, 5'd0);
        cycle(5'b00000, 4'd2, 1'b0, 1'b1, 1'b1, 5'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(5'b00000, 4'd2, 1'b0, 1'(i % 2), 1'b0, 5'd0);
            chk("s4_hold_sel", 32'(obs_sel), 32'd2);
        end
        cycle(5'b00000, 4'd2, 1'b0, 1'b1, 1'b1, 5'd0);
        cycle(5'b00000, 4'd2, 1'b0, 1'b1, 1'b1, 5'd0);
        chk("s4_beats", 32'(beats), 32'd2);
        chk("s4_idle",  32'(obs_busy), 32'd0);

        // Burst length 0 means 16 beats.
        do_reset();
        beats = 0;
        cycle(5'b00010, 4'd0, 1'b0, 1'b1, 1'b1, 5'd0);
        for (int i = 0; i < 18; i++) cycle(5'b00000, 4'd0, 1'b0, 1'b1, 1'b1, 5'd0);
        chk("s5_beats", 32'(beats), 32'd16);
        cycle(5'b01000, 4'd1, 1'b0, 1'b1, 1'b1, 5'd0);
        cycle(5'b00000, 4'd1, 1'b0, 1'b1, 1'b1, 5'd0);
        chk("s5_regrant_D", 32'(obs_sel), 32'd3);

        // Reset during beat 2 of a 5-beat burst on D.
        do_reset();
        cycle(5'b01000, 4'd5, 1'b0, 1'b1, 1'b1, 5'd0);
        cycle(5'b00000, 4'd5, 1'b0, 1'b1, 1'b1, 5'd0);
        src_valid = 5'd0; mux_z_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("s6_pre_out_valid", 32'(out_valid), 32'd1);
        do_reset();
        cycle(5'b11111, 4'd1, 1'b0, 1'b1, 1'b1, 5'd0);
        cycle(5'b00000, 4'd1, 1'b0, 1'b1, 1'b1, 5'd0);
        chk("s6_first_A", 32'(obs_sel), 32'd0);

        // Burst of 8 on A with a last flag on beat 3.
        do_reset();
        beats = 0;
        cycle(5'b00001, 4'd8, 1'b0, 1'b1, 1'b1, 5'd0);
        cycle(5'b00000, 4'd8, 1'b0, 1'b1, 1'b1, 5'd0);
        cycle(5'b00000, 4'd8, 1'b0, 1'b1, 1'b1, 5'd0);
        cycle(5'b00000, 4'd8, 1'b0, 1'b1, 1'b1, 5'b00001);
        for (int i = 0; i < 8; i++) cycle(5'b00000, 4'd8, 1'b0, 1'b1, 1'b1, 5'd0);
`ifdef DATAPATH_SRC_MUX51_SCHED_LAST_EN
        chk("s7_last_beats", 32'(beats), 32'd3);
`else
        chk("s7_last_beats", 32'(beats), 32'd8);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] sv;
            logic [4:0] lst;
            sv  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lst = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
            cycle(sv, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), lst);
            if (i % 700 == 350) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
